m3_commutation_sequencer: RTL and testbench

//  Six-step (trapezoidal) commutation controller for the 3-phase bridge.

---
 rtl/m3_commutation_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_m3_commutation_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/m3_commutation_sequencer.sv
// m3_commutation_sequencer
// Six-step trapezoidal commutation controller for a 3-phase bridge.
// Sequences IDLE -> ALIGN -> RUN -> STOP and produces the per-phase
// down1_up2 command (0 float, 1 low side, 2 high side). It also handles
// step rate (speed) and PWM duty (power) from pulse inputs.
// Optional feature macro: M3_BRAKE_EN (STOP drives all phases low side
// for braking; without it, STOP lets all phases float).
module m3_commutation_sequencer #(
   parameter int PERIOD_W    = 20,
   parameter int PERIOD_INIT = 100000,
   parameter int PERIOD_MIN  = 1000,
   parameter int PERIOD_STEP = 1000,
   parameter int ALIGN_CYC   = 200000,
   parameter int PWM_W       = 8,
   parameter int DUTY_INIT   = 64,
   parameter int DUTY_STEP   = 8
) (
   input  logic       clkI,
   input  logic       nRstI,
   input  logic       m3startI,
   input  logic       m3forceStopI,
   input  logic       m3invRotateI,
   input  logic       m3speedINCi,
   input  logic       m3speedDECi,
   input  logic       m3powerINCi,
   input  logic       m3powerDECi,
   output logic [1:0] aModeO,
   output logic [1:0] bModeO,
   output logic [1:0] cModeO,
   output logic [2:0] stepIdxO,
   output logic       runningO
);

   typedef enum logic [1:0] {IDLE, ALIGN, RUN, STOP} state_t;

   // The align time is counted in the step counter, so ALIGN_CYC must fit in PERIOD_W bits.
   localparam logic [PERIOD_W-1:0] P_INIT     = PERIOD_W'(PERIOD_INIT);
   localparam logic [PERIOD_W-1:0] P_MIN      = PERIOD_W'(PERIOD_MIN);
   localparam logic [PERIOD_W-1:0] P_STEP     = PERIOD_W'(PERIOD_STEP);
   localparam logic [PERIOD_W-1:0] ALIGN_LAST = PERIOD_W'(ALIGN_CYC - 1);
   localparam logic [PERIOD_W:0]   P_FAST_LIM = (PERIOD_W+1)'(PERIOD_MIN + PERIOD_STEP);
   localparam logic [PWM_W-1:0]    D_INIT     = PWM_W'(DUTY_INIT);
   localparam logic [PWM_W-1:0]    D_STEP     = PWM_W'(DUTY_STEP);
   localparam logic [PWM_W-1:0]    D_MAX      = {PWM_W{1'b1}};

`ifdef M3_BRAKE_EN
   localparam logic [1:0] STOP_MODE = 2'd1;
`else
   localparam logic [1:0] STOP_MODE = 2'd0;
`endif

   state_t              state_reg, state_next;
   logic [2:0]          step_idx_reg, step_idx_next;
   logic [PERIOD_W-1:0] step_cnt_reg, step_cnt_next;
   logic [PERIOD_W-1:0] period_reg, period_next;
   logic [PWM_W-1:0]    pwm_cnt_reg, pwm_cnt_next;
   logic [PWM_W-1:0]    duty_reg, duty_next;
   logic [5:0]          target;
   logic [5:0]          mode_next;
   logic [5:0]          mode_reg;
   logic [1:0]          hi_on;

   // Next-state, step sequencing, speed and power adjustment.
   always_comb begin
      state_next    = state_reg;
      step_idx_next = step_idx_reg;
      step_cnt_next = step_cnt_reg;
      period_next   = period_reg;
      pwm_cnt_next  = pwm_cnt_reg;
      duty_next     = duty_reg;
      unique case (state_reg)
         IDLE: begin
            if (m3startI && !m3forceStopI) begin
               state_next    = ALIGN;
               step_idx_next = '0;
               step_cnt_next = '0;
               pwm_cnt_next  = '0;
               period_next   = P_INIT;
               duty_next     = D_INIT;
            end
         end
         ALIGN: begin
            if (m3forceStopI) begin
               state_next = STOP;
            end else begin
               pwm_cnt_next = pwm_cnt_reg + 1'b1;
               if (step_cnt_reg == ALIGN_LAST) begin
                  state_next    = RUN;
                  step_cnt_next = '0;
               end else begin
                  step_cnt_next = step_cnt_reg + 1'b1;
               end
            end
         end
         RUN: begin
            if (m3forceStopI) begin
               state_next = STOP;
            end else begin
               pwm_cnt_next = pwm_cnt_reg + 1'b1;
               // >= so a freshly shortened period steps on the next cycle
               if (step_cnt_reg >= period_reg - 1'b1) begin
                  step_cnt_next = '0;
                  if (m3invRotateI)
                     step_idx_next = (step_idx_reg == 3'd0) ? 3'd5 : step_idx_reg - 1'b1;
                  else
                     step_idx_next = (step_idx_reg == 3'd5) ? 3'd0 : step_idx_reg + 1'b1;
               end else begin
                  step_cnt_next = step_cnt_reg + 1'b1;
               end
               if (m3speedINCi && !m3speedDECi) begin
                  period_next = ({1'b0, period_reg} >= P_FAST_LIM) ? period_reg - P_STEP : P_MIN;
               end else if (m3speedDECi && !m3speedINCi) begin
                  period_next = ({1'b0, period_reg} + {1'b0, P_STEP} > {1'b0, P_INIT})
                                ? P_INIT : period_reg + P_STEP;
               end
               if (m3powerINCi && !m3powerDECi) begin
                  duty_next = ({1'b0, duty_reg} + {1'b0, D_STEP} > {1'b0, D_MAX})
                              ? D_MAX : duty_reg + D_STEP;
               end else if (m3powerDECi && !m3powerINCi) begin
                  duty_next = (duty_reg < D_STEP) ? '0 : duty_reg - D_STEP;
               end
            end
         end
         STOP: begin
            if (!m3forceStopI) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Desired phase pattern from the current step and PWM phase; stop request overrides at once.
   always_comb begin
      target = '0;
      hi_on  = (pwm_cnt_reg < duty_reg) ? 2'd2 : 2'd0;
      if (state_reg == IDLE) begin
         target = '0;
      end else if (state_reg == STOP || m3forceStopI) begin
         target = {3{STOP_MODE}};
      end else begin
         // packing {C, B, A}; high side chopped by PWM, low side held on
         case (step_idx_reg)
            3'd0:    target = {2'd0, 2'd1, hi_on};
            3'd1:    target = {2'd1, 2'd0, hi_on};
            3'd2:    target = {2'd1, hi_on, 2'd0};
            3'd3:    target = {2'd0, hi_on, 2'd1};
            3'd4:    target = {hi_on, 2'd0, 2'd1};
            3'd5:    target = {hi_on, 2'd1, 2'd0};
            default: target = '0;
         endcase
      end
   end

   // A phase never jumps directly between high and low side: it floats for one cycle first.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_phase
         logic [1:0] want;
         logic [1:0] cur;
         assign want = target[2*gi +: 2];
         assign cur  = mode_reg[2*gi +: 2];
         assign mode_next[2*gi +: 2] =
            ((want == 2'd2 && cur == 2'd1) || (want == 2'd1 && cur == 2'd2)) ? 2'd0 : want;
      end
   endgenerate

   // State, counters and registered phase commands.
   always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI) begin
         state_reg    <= IDLE;
         step_idx_reg <= '0;
         step_cnt_reg <= '0;
         period_reg   <= P_INIT;
         pwm_cnt_reg  <= '0;
         duty_reg     <= D_INIT;
         mode_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         step_idx_reg <= step_idx_next;
         step_cnt_reg <= step_cnt_next;
         period_reg   <= period_next;
         pwm_cnt_reg  <= pwm_cnt_next;
         duty_reg     <= duty_next;
         mode_reg     <= mode_next;
      end
   end

   assign aModeO   = mode_reg[1:0];
   assign bModeO   = mode_reg[3:2];
   assign cModeO   = mode_reg[5:4];
   assign stepIdxO = step_idx_reg;
   assign runningO = (state_reg == ALIGN) || (state_reg == RUN);

endmodule

// File: tb/tb_m3_commutation_sequencer.sv
// Testbench for m3_commutation_sequencer: random and directed pulse stimulus
// compared each cycle against a behavioural model of the commutation rules.
module tb_m3_commutation_sequencer;

   localparam int P_INIT = 20;
   localparam int P_MIN  = 4;
   localparam int P_STEP = 4;
   localparam int A_CYC  = 10;
   localparam int PWM_W  = 3;
   localparam int D_INIT = 4;
   localparam int D_STEP = 2;
   localparam int D_MAX  = (1 << PWM_W) - 1;

   logic       clkI = 1'b0;
   logic       nRstI;
   logic       m3startI, m3forceStopI, m3invRotateI;
   logic       m3speedINCi, m3speedDECi, m3powerINCi, m3powerDECi;
   logic [1:0] aModeO, bModeO, cModeO;
   logic [2:0] stepIdxO;
   logic       runningO;

   always #5 clkI = ~clkI;

   m3_commutation_sequencer #(
      .PERIOD_W(20), .PERIOD_INIT(P_INIT), .PERIOD_MIN(P_MIN), .PERIOD_STEP(P_STEP),
      .ALIGN_CYC(A_CYC), .PWM_W(PWM_W), .DUTY_INIT(D_INIT), .DUTY_STEP(D_STEP)
   ) dut (
      .clkI(clkI), .nRstI(nRstI),
      .m3startI(m3startI), .m3forceStopI(m3forceStopI), .m3invRotateI(m3invRotateI),
      .m3speedINCi(m3speedINCi), .m3speedDECi(m3speedDECi),
      .m3powerINCi(m3powerINCi), .m3powerDECi(m3powerDECi),
      .aModeO(aModeO), .bModeO(bModeO), .cModeO(cModeO),
      .stepIdxO(stepIdxO), .runningO(runningO)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // model: 0 idle, 1 align, 2 run, 3 stop
   int m_state, m_step, m_pwm, m_cnt, m_period, m_duty;
   int m_mode[3];
   int hi_ph[6] = '{0, 0, 1, 1, 2, 2};
   int lo_ph[6] = '{1, 2, 2, 0, 0, 1};

   task automatic check_value(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_step = 0; m_pwm = 0; m_cnt = 0;
      m_period = P_INIT; m_duty = D_INIT;
      for (int i = 0; i < 3; i++) m_mode[i] = 0;
   endtask

   // One clock edge of the commutation rules.
   task automatic model_update(input int st, input int fs, input int inv,
                               input int si, input int sd, input int pi, input int pd);
      for (int i = 0; i < 3; i++) m_mode[i] = 0;
      if ((m_state == 1 || m_state == 2) && fs == 0) begin
         m_mode[hi_ph[m_step]] = (m_pwm < m_duty) ? 2 : 0;
         m_mode[lo_ph[m_step]] = 1;
      end
      case (m_state)
         0: if (st != 0 && fs == 0) begin
               m_state = 1; m_step = 0; m_cnt = 0; m_pwm = 0;
               m_period = P_INIT; m_duty = D_INIT;
            end
         1: if (fs != 0) m_state = 3;
            else begin
               m_pwm = (m_pwm + 1) % (D_MAX + 1);
               m_cnt++;
               if (m_cnt == A_CYC) begin m_state = 2; m_cnt = 0; end
            end
         2: if (fs != 0) m_state = 3;
            else begin
               m_pwm = (m_pwm + 1) % (D_MAX + 1);
               if (m_cnt >= m_period - 1) begin
                  m_cnt = 0;
                  m_step = (inv != 0) ? (m_step + 5) % 6 : (m_step + 1) % 6;
               end else m_cnt++;
               if (si != 0 && sd == 0) m_period = (m_period - P_STEP < P_MIN) ? P_MIN : m_period - P_STEP;
               if (sd != 0 && si == 0) m_period = (m_period + P_STEP > P_INIT) ? P_INIT : m_period + P_STEP;
               if (pi != 0 && pd == 0) m_duty = (m_duty + D_STEP > D_MAX) ? D_MAX : m_duty + D_STEP;
               if (pd != 0 && pi == 0) m_duty = (m_duty - D_STEP < 0) ? 0 : m_duty - D_STEP;
            end
         default: if (fs == 0) m_state = 0;
      endcase
   endtask

   task automatic compare_outputs();
      check_value("running", int'(runningO), (m_state == 1 || m_state == 2) ? 1 : 0);
      check_value("stepIdx", int'(stepIdxO), m_step);
      check_value("aMode", int'(aModeO), m_mode[0]);
      check_value("bMode", int'(bModeO), m_mode[1]);
      check_value("cMode", int'(cModeO), m_mode[2]);
   endtask

   // One cycle: drive inputs at the falling edge, model the rising edge, check at the next falling edge.
   task automatic tick(input int st, input int fs, input int inv,
                       input int si, input int sd, input int pi, input int pd);
      m3startI = st[0]; m3forceStopI = fs[0]; m3invRotateI = inv[0];
      m3speedINCi = si[0]; m3speedDECi = sd[0]; m3powerINCi = pi[0]; m3powerDECi = pd[0];
      @(posedge clkI);
      model_update(st, fs, inv, si, sd, pi, pd);
      @(negedge clkI);
      cyc++;
      compare_outputs();
      $display("cyc=%0d in=%0d%0d%0d%0d%0d%0d%0d run=%0b step=%0d A=%0d B=%0d C=%0d",
               cyc, st, fs, inv, si, sd, pi, pd, runningO, stepIdxO, aModeO, bModeO, cModeO);
   endtask

   task automatic idle_ticks(input int n, input int inv);
      for (int i = 0; i < n; i++) tick(0, 0, inv, 0, 0, 0, 0);
   endtask

   task automatic random_segment(input int n, input int inv, input int fs);
      for (int i = 0; i < n; i++)
         tick(($urandom % 20) == 0, fs, inv, ($urandom % 8) == 0, ($urandom % 8) == 0,
              ($urandom % 8) == 0, ($urandom % 8) == 0);
   endtask

   initial begin
      nRstI = 1'b0;
      m3startI = 0; m3forceStopI = 0; m3invRotateI = 0;
      m3speedINCi = 0; m3speedDECi = 0; m3powerINCi = 0; m3powerDECi = 0;
      model_reset();
      @(negedge clkI);
      @(negedge clkI);
      compare_outputs();
      nRstI = 1'b1;

      // start, align, forward run of several steps
      tick(1, 0, 0, 0, 0, 0, 0);
      idle_ticks(A_CYC + 7 * P_INIT + 2, 0);
      // reverse
      idle_ticks(3 * P_INIT, 1);
      // speed saturates fast, then slow
      for (int i = 0; i < 6; i++) begin tick(0, 0, 0, 1, 0, 0, 0); idle_ticks(9, 0); end
      for (int i = 0; i < 7; i++) begin tick(0, 0, 0, 0, 1, 0, 0); idle_ticks(9, 0); end
      tick(0, 0, 0, 1, 1, 0, 0);
      // power up to saturation, down to zero, simultaneous pulses
      for (int i = 0; i < 3; i++) begin tick(0, 0, 0, 0, 0, 1, 0); idle_ticks(8, 0); end
      idle_ticks(16, 0);
      for (int i = 0; i < 5; i++) begin tick(0, 0, 0, 0, 0, 0, 1); idle_ticks(8, 0); end
      idle_ticks(16, 0);
      tick(0, 0, 0, 0, 0, 1, 1);
      idle_ticks(16, 0);
      // force stop mid-run, release, start masked by stop
      for (int i = 0; i < 4; i++) tick(1, 1, 0, 1, 0, 1, 0);
      idle_ticks(3, 0);
      tick(1, 1, 0, 0, 0, 0, 0);
      idle_ticks(4, 0);

      // random segments
      for (int k = 0; k < 30; k++) begin
         tick(1, 0, 0, 0, 0, 0, 0);
         random_segment(30 + int'($urandom % 90), int'($urandom % 2), 0);
         if ($urandom % 3 == 0) random_segment(1 + int'($urandom % 4), 0, 1);
      end

      // asynchronous reset mid-run
      tick(1, 0, 0, 0, 0, 0, 0);
      idle_ticks(A_CYC + 25, 0);
      @(posedge clkI);
      #3 nRstI = 1'b0;
      #1;
      check_value("async_rst_a", int'(aModeO), 0);
      check_value("async_rst_b", int'(bModeO), 0);
      check_value("async_rst_c", int'(cModeO), 0);
      check_value("async_rst_step", int'(stepIdxO), 0);
      check_value("async_rst_run", int'(runningO), 0);
      @(negedge clkI);
      model_reset();
      compare_outputs();
      nRstI = 1'b1;
      idle_ticks(3, 0);
      tick(1, 0, 0, 0, 0, 0, 0);
      idle_ticks(A_CYC + 30, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
